booth_mult: RTL and testbench

//  Multicycle signed multiplier (radix-2 Booth) for the multicycle MIPS datapath; the multiply

---
 rtl/mult_pkg.sv | 20 ++
 rtl/booth_step.sv | 40 ++++
 rtl/booth_mult.sv | 95 +++++++++
 tb/tb_booth_mult.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier.
//   WIDTH_DEF  : default operand width (product is 2*WIDTH_DEF bits)
//   state_t    : multiplier FSM states
//   cnt_width  : step-counter width for a given operand width
package mult_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter has to be able to hold WIDTH, hence WIDTH+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   acc, q, q1      : current {A,Q,q_1}; A is WIDTH+1 bits
//   m               : multiplicand
//   acc_nx, q_nx, q1_nx : {A,Q,q_1} after add/sub and arithmetic shift right
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_nx,
  output logic [WIDTH-1:0] q_nx,
  output logic             q1_nx
);

  logic [WIDTH:0] msx;
  logic [WIDTH:0] sum;

  // The extra accumulator bit keeps -2^(WIDTH-1) * -2^(WIDTH-1) from
  // overflowing the partial sum.
  assign msx = {m[WIDTH-1], m};

  always_comb begin
    sum = acc;
    case ({q[0], q1})
      2'b10:   sum = acc - msx;
      2'b01:   sum = acc + msx;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift right of the whole {A,Q,q_1} chain; old q_1 falls off.
  assign acc_nx = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nx   = {sum[0], q[WIDTH-1:1]};
  assign q1_nx  = q[0];

endmodule

// File: rtl/booth_mult.sv
// Multicycle signed radix-2 Booth multiplier with start/busy/done handshake.
//   clk, rst : clock and synchronous active-high reset
//   start    : request, only honoured in IDLE; a/b are latched with it
//   a, b     : two's complement multiplicand / multiplier
//   busy     : high for the WIDTH iteration cycles
//   done     : one-cycle pulse; hi/lo hold the product from this cycle on
//   hi, lo   : upper / lower halves of the 2*WIDTH-bit signed product
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             q1;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] mq_nx;
  logic             q1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .q      (mq),
    .q1     (q1),
    .m      (mcand),
    .acc_nx (acc_nx),
    .q_nx   (mq_nx),
    .q1_nx  (q1_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      acc   <= '0;
      mq    <= '0;
      q1    <= 1'b0;
      mcand <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            q1    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nx;
          mq  <= mq_nx;
          q1  <= q1_nx;
          cnt <= cnt + 1'b1;
          // cnt counts completed steps, so WIDTH-1 means this edge does the last one.
          if (cnt == CW'(WIDTH - 1)) begin
            hi    <= acc_nx[WIDTH-1:0];
            lo    <= mq_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int passed = 0;

  booth_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit signed arithmetic.
  function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint px, py;
    px = longint'($signed(x));
    py = longint'($signed(y));
    return 64'(px * py);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, scramble a/b right after launch, wait for done,
  // check latency, busy length, product, and that it holds after done.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
    logic [63:0] exp;
    int edges, bcyc;
    exp = model(xa, xb);
    a = xa; b = xb; start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom; b = $urandom;
    edges = 0; bcyc = 0;
    while (!done && edges < 100) begin
      if (busy) bcyc++;
      step();
      edges++;
    end
    chk({tag, ".latency"}, 64'(edges), 64'd32);
    chk({tag, ".busycyc"}, 64'(bcyc), 64'd32);
    chk({tag, ".prod"}, {hi, lo}, exp);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    step();
    chk({tag, ".done_drop"}, 64'(done), 64'd0);
    chk({tag, ".hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int dcount, n;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    step(); step();
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    step();

    do_op(32'd7, 32'hFFFFFFFD, "t1");
    chk("t1.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op(32'h80000000, 32'h80000000, "t2");
    chk("t2.const", {hi, lo}, 64'h40000000_00000000);
    do_op(32'h7FFFFFFF, 32'h7FFFFFFF, "t3a");
    chk("t3a.const", {hi, lo}, 64'h3FFFFFFF_00000001);
    do_op(32'd0, 32'h12345678, "t3b");
    do_op(32'h80000000, 32'h7FFFFFFF, "t3c");
    // Back-to-back: do_op returns in the IDLE cycle right after done.
    do_op(32'd2, 32'hFFFFFFFB, "t6");
    chk("t6.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF6);

    // start held high across RUN and DONE; a/b change mid-run.
    a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    a = 32'd100; b = 32'd100;
    n = 0; dcount = 0;
    while (!done && n < 100) begin step(); n++; end
    chk("t4.latency", 64'(n), 64'd32);
    chk("t4.prod", {hi, lo}, model(32'd3, 32'd5));
    step();   // DONE -> IDLE with start still high: must not launch
    chk("t4.no_relaunch", 64'(busy), 64'd0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) dcount++;
      step();
    end
    chk("t4.single_done", 64'(dcount), 64'd0);
    chk("t4.hold", {hi, lo}, model(32'd3, 32'd5));

    // Reset in the 10th RUN cycle abandons the operation.
    a = 32'h12345; b = 32'h6789; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("t5.busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    chk("t5.busy", 64'(busy), 64'd0);
    chk("t5.done", 64'(done), 64'd0);
    chk("t5.hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      step();
    end
    chk("t5.no_done", 64'(dcount), 64'd0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, "t5b");
    chk("t5b.const", {hi, lo}, 64'h00000000_00000001);

    // Randomized operands, with occasional corner values mixed in.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: rb = 32'h80000000;
        2: ra = 32'hFFFFFFFF;
        default: ;
      endcase
      do_op(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
